// File: rtl/csr_port_arbiter_pkg.sv
// Shared definitions for the CSR port arbiter: FSM state encodings, round-robin
// owner encoding and the CSR address map entries touched by configuration sequences.
package csr_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_ARB     = 2'b00,
        ARB_CU_LOCK = 2'b01,
        ARB_RESV0   = 2'b10,
        ARB_RESV1   = 2'b11
    } arb_state_e;

    typedef enum logic {
        RR_CU = 1'b0,
        RR_PS = 1'b1
    } rr_owner_e;

    localparam logic [31:0] CSR_ADDR_PRECISION = 32'h0000_0002;
    localparam logic [31:0] CSR_ADDR_FP_MODE   = 32'h0000_0004;

    function automatic int lock_cnt_width(input int max_cycles);
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/csr_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant from the current pointer,
// pointer moves to the loser after a committed grant or is forced to the PS side.
module rr_arbiter2
    import csr_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_cu,
    input  logic req_ps,
    input  logic update,
    input  logic force_ps,
    output logic gnt_cu,
    output logic gnt_ps
);

    rr_owner_e ptr_q;

    always_comb begin
        gnt_cu = req_cu & (~req_ps | (ptr_q == RR_CU));
        gnt_ps = req_ps & (~req_cu | (ptr_q == RR_PS));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= RR_CU;
        end else if (force_ps) begin
            ptr_q <= RR_PS;
        end else if (update && gnt_cu) begin
            ptr_q <= RR_PS;
        end else if (update && gnt_ps) begin
            ptr_q <= RR_CU;
        end
    end

endmodule

// File: rtl/csr_port_arbiter.sv
// Shares the single-port CSR memory between the control unit and the PS host, with
// round-robin arbitration, a CU lock for configuration sequences and a lock watchdog.
module csr_port_arbiter
    import csr_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH_CSR   = 8,
    parameter int ADDRESS_SIZE_CSR = 32,
    parameter int MAX_LOCK_CYCLES  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cu_req,
    input  logic                        cu_we,
    input  logic [ADDRESS_SIZE_CSR-1:0] cu_addr,
    input  logic [DATA_WIDTH_CSR-1:0]   cu_wdata,
    input  logic                        cu_lock,
    input  logic                        ps_req,
    input  logic                        ps_we,
    input  logic [ADDRESS_SIZE_CSR-1:0] ps_addr,
    input  logic [DATA_WIDTH_CSR-1:0]   ps_wdata,
    output logic                        cu_gnt,
    output logic                        ps_gnt,
    output logic                        cu_rvalid,
    output logic                        ps_rvalid,
    output logic [DATA_WIDTH_CSR-1:0]   cu_rdata,
    output logic [DATA_WIDTH_CSR-1:0]   ps_rdata,
    output logic                        csr_ce,
    output logic                        csr_we,
    output logic [ADDRESS_SIZE_CSR-1:0] csr_address,
    output logic [DATA_WIDTH_CSR-1:0]   csr_din,
    input  logic [DATA_WIDTH_CSR-1:0]   csr_dout,
    output logic                        lock_timeout,
    output logic [1:0]                  arb_state
);

    localparam int CNT_W = lock_cnt_width(MAX_LOCK_CYCLES);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             armed_q, armed_d;
    logic             arb_cu, arb_ps;
    logic             issue_cu, issue_ps;
    logic             rr_update, rr_force_ps;
    logic             timeout_d;
    logic             issue_we;
    logic             vld_cu_p2, vld_ps_p2;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_cu   (cu_req),
        .req_ps   (ps_req),
        .update   (rr_update),
        .force_ps (rr_force_ps),
        .gnt_cu   (arb_cu),
        .gnt_ps   (arb_ps)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB_ARB;
            lock_cnt_q <= '0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            armed_q    <= armed_d;
        end
    end

    // After a watchdog break the lock stays disarmed until cu_lock is seen low once.
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        armed_d     = cu_lock ? armed_q : 1'b1;
        issue_cu    = 1'b0;
        issue_ps    = 1'b0;
        timeout_d   = 1'b0;
        rr_update   = 1'b0;
        rr_force_ps = 1'b0;
        case (state_q)
            ARB_ARB: begin
                rr_update = 1'b1;
                issue_cu  = arb_cu;
                issue_ps  = arb_ps;
                if (arb_cu && cu_lock && armed_q) begin
                    state_d    = ARB_CU_LOCK;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            ARB_CU_LOCK: begin
                if (!cu_lock) begin
                    state_d     = ARB_ARB;
                    lock_cnt_d  = '0;
                    rr_force_ps = 1'b1;
                end else if (lock_cnt_q == CNT_W'(MAX_LOCK_CYCLES)) begin
                    state_d     = ARB_ARB;
                    lock_cnt_d  = '0;
                    rr_force_ps = 1'b1;
                    timeout_d   = 1'b1;
                    armed_d     = 1'b0;
                end else begin
                    issue_cu   = cu_req;
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ARB_ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    assign issue_we = issue_cu ? cu_we : (issue_ps ? ps_we : 1'b0);

    // p1: access presented to memory; p2: read data returned to the issuer
    always_ff @(posedge clk) begin
        if (!reset) begin
            cu_gnt       <= 1'b0;
            ps_gnt       <= 1'b0;
            csr_ce       <= 1'b0;
            csr_we       <= 1'b0;
            csr_address  <= '0;
            csr_din      <= '0;
            lock_timeout <= 1'b0;
            vld_cu_p2    <= 1'b0;
            vld_ps_p2    <= 1'b0;
        end else begin
            cu_gnt       <= issue_cu;
            ps_gnt       <= issue_ps;
            csr_ce       <= issue_cu | issue_ps;
            csr_we       <= issue_we;
            csr_address  <= issue_cu ? cu_addr : (issue_ps ? ps_addr : '0);
            csr_din      <= !issue_we ? '0 : (issue_cu ? cu_wdata : ps_wdata);
            lock_timeout <= timeout_d;
            vld_cu_p2    <= cu_gnt & ~csr_we;
            vld_ps_p2    <= ps_gnt & ~csr_we;
        end
    end

    assign cu_rvalid = vld_cu_p2;
    assign ps_rvalid = vld_ps_p2;
    assign cu_rdata  = vld_cu_p2 ? csr_dout : '0;
    assign ps_rdata  = vld_ps_p2 ? csr_dout : '0;
    assign arb_state = state_q;

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Bench for csr_port_arbiter: directed vector table, lock/watchdog sequences and
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_csr_port_arbiter;

    localparam int MAXL = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cu_req, cu_we, cu_lock, ps_req, ps_we;
    logic [31:0] cu_addr, ps_addr;
    logic [7:0]  cu_wdata, ps_wdata;
    logic        cu_gnt, ps_gnt, cu_rvalid, ps_rvalid;
    logic [7:0]  cu_rdata, ps_rdata;
    logic        csr_ce, csr_we;
    logic [31:0] csr_address;
    logic [7:0]  csr_din, csr_dout;
    logic        lock_timeout;
    logic [1:0]  arb_state;

    int checks = 0;
    int errors = 0;

    csr_port_arbiter #(
        .DATA_WIDTH_CSR   (8),
        .ADDRESS_SIZE_CSR (32),
        .MAX_LOCK_CYCLES  (MAXL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cu_req       (cu_req),
        .cu_we        (cu_we),
        .cu_addr      (cu_addr),
        .cu_wdata     (cu_wdata),
        .cu_lock      (cu_lock),
        .ps_req       (ps_req),
        .ps_we        (ps_we),
        .ps_addr      (ps_addr),
        .ps_wdata     (ps_wdata),
        .cu_gnt       (cu_gnt),
        .ps_gnt       (ps_gnt),
        .cu_rvalid    (cu_rvalid),
        .ps_rvalid    (ps_rvalid),
        .cu_rdata     (cu_rdata),
        .ps_rdata     (ps_rdata),
        .csr_ce       (csr_ce),
        .csr_we       (csr_we),
        .csr_address  (csr_address),
        .csr_din      (csr_din),
        .csr_dout     (csr_dout),
        .lock_timeout (lock_timeout),
        .arb_state    (arb_state)
    );

    initial forever #5 clk = ~clk;

    // Synchronous-read CSR memory driven by the DUT.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (csr_ce) begin
            if (csr_we) mem[csr_address[7:0]] <= csr_din;
            else        csr_dout <= mem[csr_address[7:0]];
        end
    end

    // Behavioural model state and per-cycle expectations.
    logic [7:0]  ref_mem [256];
    bit          m_locked, m_armed, m_ptr_ps, m_pend_cu, m_pend_ps;
    int          m_len;
    logic [7:0]  m_pend_data;
    logic        e_cu_gnt, e_ps_gnt, e_ce, e_we, e_to, e_cu_rv, e_ps_rv;
    logic [31:0] e_addr;
    logic [7:0]  e_din, e_cu_rd, e_ps_rd;
    logic [1:0]  e_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit win_cu, win_ps, to;
        win_cu = 1'b0;
        win_ps = 1'b0;
        to     = 1'b0;
        if (!reset) begin
            m_locked = 1'b0; m_len = 0; m_armed = 1'b1; m_ptr_ps = 1'b0;
            m_pend_cu = 1'b0; m_pend_ps = 1'b0;
            e_cu_gnt = 1'b0; e_ps_gnt = 1'b0; e_ce = 1'b0; e_we = 1'b0; e_to = 1'b0;
            e_cu_rv = 1'b0; e_ps_rv = 1'b0; e_addr = '0; e_din = '0;
            e_cu_rd = '0; e_ps_rd = '0; e_state = 2'd0;
            return;
        end
        e_cu_rv = m_pend_cu;
        e_ps_rv = m_pend_ps;
        e_cu_rd = m_pend_cu ? m_pend_data : 8'h00;
        e_ps_rd = m_pend_ps ? m_pend_data : 8'h00;
        if (m_locked) begin
            if (!cu_lock) begin
                m_locked = 1'b0; m_ptr_ps = 1'b1;
            end else if (m_len == MAXL) begin
                to = 1'b1; m_locked = 1'b0; m_ptr_ps = 1'b1; m_armed = 1'b0;
            end else begin
                m_len++;
                win_cu = cu_req;
            end
        end else begin
            if (cu_req && ps_req) begin
                win_ps = m_ptr_ps;
                win_cu = !m_ptr_ps;
            end else begin
                win_cu = cu_req;
                win_ps = ps_req;
            end
            if (win_cu) m_ptr_ps = 1'b1;
            if (win_ps) m_ptr_ps = 1'b0;
            if (win_cu && cu_lock && m_armed) begin
                m_locked = 1'b1; m_len = 1;
            end
        end
        if (!cu_lock) m_armed = 1'b1;
        e_cu_gnt = win_cu;
        e_ps_gnt = win_ps;
        e_ce     = win_cu | win_ps;
        e_to     = to;
        e_state  = m_locked ? 2'd1 : 2'd0;
        e_we     = win_cu ? cu_we : (win_ps ? ps_we : 1'b0);
        e_addr   = win_cu ? cu_addr : (win_ps ? ps_addr : 32'h0);
        e_din    = !e_we ? 8'h00 : (win_cu ? cu_wdata : ps_wdata);
        m_pend_cu = win_cu && !cu_we;
        m_pend_ps = win_ps && !ps_we;
        if (e_ce && !e_we) m_pend_data = ref_mem[e_addr[7:0]];
        if (e_ce && e_we)  ref_mem[e_addr[7:0]] = e_din;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("m_cu_gnt",    32'(cu_gnt),       32'(e_cu_gnt));
        chk("m_ps_gnt",    32'(ps_gnt),       32'(e_ps_gnt));
        chk("m_csr_ce",    32'(csr_ce),       32'(e_ce));
        chk("m_csr_we",    32'(csr_we),       32'(e_we));
        chk("m_csr_addr",  csr_address,       e_addr);
        chk("m_csr_din",   32'(csr_din),      32'(e_din));
        chk("m_cu_rvalid", 32'(cu_rvalid),    32'(e_cu_rv));
        chk("m_ps_rvalid", 32'(ps_rvalid),    32'(e_ps_rv));
        chk("m_cu_rdata",  32'(cu_rdata),     32'(e_cu_rd));
        chk("m_ps_rdata",  32'(ps_rdata),     32'(e_ps_rd));
        chk("m_timeout",   32'(lock_timeout), 32'(e_to));
        chk("m_state",     32'(arb_state),    32'(e_state));
    endtask

    task automatic idle_inputs();
        cu_req = 1'b0; cu_we = 1'b0; cu_addr = '0; cu_wdata = '0; cu_lock = 1'b0;
        ps_req = 1'b0; ps_we = 1'b0; ps_addr = '0; ps_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    typedef struct {
        bit          rst_n;
        bit          cu_req, cu_we;
        logic [31:0] cu_addr;
        bit          ps_req, ps_we;
        logic [31:0] ps_addr;
        logic [7:0]  ps_wdata;
        bit          e_cu_gnt, e_ps_gnt;
        logic [31:0] e_addr;
        bit          e_we;
        logic [7:0]  e_din;
        bit          e_cu_rv, e_ps_rv;
        logic [7:0]  e_cu_rd, e_ps_rd;
    } vec_t;

    function automatic vec_t mk(bit rst_n, bit cr, bit cw, logic [31:0] ca,
                                bit pr, bit pw, logic [31:0] pa, logic [7:0] pd,
                                bit ecg, bit epg, logic [31:0] ea, bit ewe, logic [7:0] edin,
                                bit ecv, bit epv, logic [7:0] ecd, logic [7:0] epd);
        vec_t v;
        v.rst_n = rst_n; v.cu_req = cr; v.cu_we = cw; v.cu_addr = ca;
        v.ps_req = pr; v.ps_we = pw; v.ps_addr = pa; v.ps_wdata = pd;
        v.e_cu_gnt = ecg; v.e_ps_gnt = epg; v.e_addr = ea; v.e_we = ewe; v.e_din = edin;
        v.e_cu_rv = ecv; v.e_ps_rv = epv; v.e_cu_rd = ecd; v.e_ps_rd = epd;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[4]     = 8'h83;
        ref_mem[4] = 8'h83;
        csr_dout   = 8'h00;
        reset      = 1'b0;
        idle_inputs();

        //          rst cr cw addr   pr pw addr   wd     cg pg addr   we din    cv pv crd    prd
        tv.push_back(mk(0, 1, 0, 32'h4, 0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        tv.push_back(mk(1, 1, 0, 32'h1, 1, 0, 32'h2, 8'h00, 1, 0, 32'h1, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        tv.push_back(mk(1, 1, 0, 32'h1, 1, 0, 32'h2, 8'h00, 0, 1, 32'h2, 0, 8'h00, 1, 0, 8'h0A, 8'h00));
        tv.push_back(mk(1, 1, 0, 32'h1, 1, 0, 32'h2, 8'h00, 1, 0, 32'h1, 0, 8'h00, 0, 1, 8'h00, 8'h11));
        tv.push_back(mk(1, 1, 0, 32'h1, 1, 0, 32'h2, 8'h00, 0, 1, 32'h2, 0, 8'h00, 1, 0, 8'h0A, 8'h00));
        tv.push_back(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 0, 8'h00, 0, 1, 8'h00, 8'h11));
        tv.push_back(mk(1, 1, 0, 32'h4, 0, 0, 32'h0, 8'h00, 1, 0, 32'h4, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        tv.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        tv.push_back(mk(1, 1, 0, 32'h4, 0, 0, 32'h0, 8'h00, 1, 0, 32'h4, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        tv.push_back(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 0, 8'h00, 1, 0, 8'h83, 8'h00));
        tv.push_back(mk(1, 0, 0, 32'h0, 1, 1, 32'h2, 8'hA5, 0, 1, 32'h2, 1, 8'hA5, 0, 0, 8'h00, 8'h00));
        tv.push_back(mk(1, 1, 0, 32'h2, 0, 0, 32'h0, 8'h00, 1, 0, 32'h2, 0, 8'h00, 0, 0, 8'h00, 8'h00));
        tv.push_back(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 0, 8'h00, 1, 0, 8'hA5, 8'h00));

        foreach (tv[k]) begin
            reset   = tv[k].rst_n;
            cu_req  = tv[k].cu_req;  cu_we = tv[k].cu_we;  cu_addr = tv[k].cu_addr;
            cu_wdata = 8'h00;        cu_lock = 1'b0;
            ps_req  = tv[k].ps_req;  ps_we = tv[k].ps_we;  ps_addr = tv[k].ps_addr;
            ps_wdata = tv[k].ps_wdata;
            step();
            chk("tv_cu_gnt",    32'(cu_gnt),    32'(tv[k].e_cu_gnt));
            chk("tv_ps_gnt",    32'(ps_gnt),    32'(tv[k].e_ps_gnt));
            chk("tv_addr",      csr_address,    tv[k].e_addr);
            chk("tv_we",        32'(csr_we),    32'(tv[k].e_we));
            chk("tv_din",       32'(csr_din),   32'(tv[k].e_din));
            chk("tv_cu_rvalid", 32'(cu_rvalid), 32'(tv[k].e_cu_rv));
            chk("tv_ps_rvalid", 32'(ps_rvalid), 32'(tv[k].e_ps_rv));
            chk("tv_cu_rdata",  32'(cu_rdata),  32'(tv[k].e_cu_rd));
            chk("tv_ps_rdata",  32'(ps_rdata),  32'(tv[k].e_ps_rd));
        end

        // CU lock for three accesses while PS waits, then release with CU still requesting.
        do_reset();
        cu_req = 1'b1; cu_lock = 1'b1; cu_addr = 32'h5;
        ps_req = 1'b1; ps_addr = 32'h6;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lk_cu_gnt", 32'(cu_gnt), 32'd1);
            chk("lk_ps_gnt", 32'(ps_gnt), 32'd0);
            chk("lk_state",  32'(arb_state), 32'd1);
        end
        cu_lock = 1'b0;
        step();
        chk("rel_no_gnt", 32'(cu_gnt | ps_gnt), 32'd0);
        chk("rel_state",  32'(arb_state), 32'd0);
        step();
        chk("rel_ps_gnt", 32'(ps_gnt), 32'd1);
        step();
        chk("rel_cu_gnt", 32'(cu_gnt), 32'd1);

        // Lock held past the watchdog limit, then re-arm only after cu_lock drops.
        do_reset();
        cu_req = 1'b1; cu_lock = 1'b1; cu_addr = 32'h5;
        ps_req = 1'b1; ps_addr = 32'h6;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("wd_cu_gnt",  32'(cu_gnt),       32'((i <= MAXL - 1) || (i == MAXL + 2)));
            chk("wd_ps_gnt",  32'(ps_gnt),       32'((i == MAXL + 1) || (i == MAXL + 3)));
            chk("wd_timeout", 32'(lock_timeout), 32'(i == MAXL));
            chk("wd_state",   32'(arb_state),    32'(i <= MAXL - 1));
        end
        cu_lock = 1'b0; ps_req = 1'b0;
        step();
        chk("rearm_gnt",   32'(cu_gnt),    32'd1);
        chk("rearm_state", 32'(arb_state), 32'd0);
        cu_lock = 1'b1;
        step();
        chk("relock_state", 32'(arb_state), 32'd1);
        cu_lock = 1'b0; cu_req = 1'b0;
        step();
        chk("unlock_state", 32'(arb_state), 32'd0);

        // Randomized traffic; requests are held until granted.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!cu_req || cu_gnt) begin
                cu_req   = ($urandom_range(0, 9) < 7);
                cu_we    = $urandom_range(0, 1) == 1;
                cu_addr  = 32'($urandom_range(0, 15));
                cu_wdata = 8'($urandom);
            end
            if (!ps_req || ps_gnt) begin
                ps_req   = ($urandom_range(0, 9) < 6);
                ps_we    = $urandom_range(0, 1) == 1;
                ps_addr  = 32'($urandom_range(0, 15));
                ps_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 11) == 0) cu_lock = ~cu_lock;
            reset = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
